// File: rtl/div_ctrl_pkg.sv
// Shared CPU definitions for the divider controller: op one-hot layout,
// FSM encoding, latency limit default and operand-class helpers.
package div_ctrl_pkg;

    localparam int OP_W        = 4;
    localparam int OP_DIV_W    = 0;
    localparam int OP_MOD_W    = 1;
    localparam int OP_DIV_WU   = 2;
    localparam int OP_MOD_WU   = 3;
    localparam int MAX_LAT_DEF = 48;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    function automatic logic op_is_signed(input logic [OP_W-1:0] op);
        return op[OP_DIV_W] | op[OP_MOD_W];
    endfunction

    function automatic logic op_is_mod(input logic [OP_W-1:0] op);
        return op[OP_MOD_W] | op[OP_MOD_WU];
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// EX-stage control for external signed/unsigned divider IPs: operand issue,
// result capture, flush/drain handling and a sticky latency watchdog.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int MAX_LAT = MAX_LAT_DEF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    input  logic [OP_W-1:0] req_op,
    input  logic [31:0]     req_src1,
    input  logic [31:0]     req_src2,
    output logic            req_ready,
    output logic            resp_valid,
    output logic [31:0]     resp_result,
    input  logic            resp_ready,
    input  logic            flush,
    output logic            busy,
    output logic            lat_err,
    output logic            sdiv_tvalid,
    input  logic            sdiv_tready,
    output logic [31:0]     sdiv_dividend,
    output logic [31:0]     sdiv_divisor,
    input  logic            sdiv_dout_valid,
    input  logic [63:0]     sdiv_dout,
    output logic            udiv_tvalid,
    input  logic            udiv_tready,
    output logic [31:0]     udiv_dividend,
    output logic [31:0]     udiv_divisor,
    input  logic            udiv_dout_valid,
    input  logic [63:0]     udiv_dout
);

    localparam int               CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LAT);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [31:0]       src1_q, src1_d;
    logic [31:0]       src2_q, src2_d;
    logic [31:0]       result_q, result_d;
    logic              kill_q, kill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              lat_err_q, lat_err_d;
    logic              rdy_q;

    logic              sel_signed, sel_tready, sel_dv;
    logic [63:0]       sel_dout;

    assign sel_signed = op_is_signed(op_q);
    assign sel_tready = sel_signed ? sdiv_tready     : udiv_tready;
    assign sel_dv     = sel_signed ? sdiv_dout_valid : udiv_dout_valid;
    assign sel_dout   = sel_signed ? sdiv_dout       : udiv_dout;
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d     = state_q;
        op_d        = op_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        result_d    = result_q;
        kill_d      = kill_q;
        cnt_d       = '0;
        lat_err_d   = lat_err_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        sdiv_tvalid = 1'b0;
        udiv_tvalid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = rdy_q;
                if (req_valid && rdy_q && !flush) begin
                    op_d    = req_op;
                    src1_d  = req_src1;
                    src2_d  = req_src2;
                    kill_d  = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                sdiv_tvalid = sel_signed;
                udiv_tvalid = !sel_signed;
                if (flush) kill_d = 1'b1;
                if (sel_tready) begin
                    state_d = (flush || kill_q) ? ST_DRAIN : ST_WAIT;
                    kill_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                // A result arriving with the flush is already drained.
                if (flush) begin
                    state_d = sel_dv ? ST_IDLE : ST_DRAIN;
                end else if (sel_dv) begin
                    result_d = op_is_mod(op_q) ? sel_dout[31:0] : sel_dout[63:32];
                    state_d  = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (sel_dv) state_d = ST_IDLE;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                if (flush || resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_WAIT || state_q == ST_DRAIN) begin
            if (cnt_inc == CNT_MAX) lat_err_d = 1'b1;
            if (state_d == ST_WAIT || state_d == ST_DRAIN) cnt_d = cnt_inc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            result_q  <= '0;
            kill_q    <= 1'b0;
            cnt_q     <= '0;
            lat_err_q <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            result_q  <= result_d;
            kill_q    <= kill_d;
            cnt_q     <= cnt_d;
            lat_err_q <= lat_err_d;
            rdy_q     <= 1'b1;
        end
    end

    assign resp_result   = result_q;
    assign busy          = (state_q != ST_IDLE);
    assign lat_err       = lat_err_q;
    assign sdiv_dividend = src1_q;
    assign sdiv_divisor  = src2_q;
    assign udiv_dividend = src1_q;
    assign udiv_divisor  = src2_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: divider handshakes, flush/drain, latency
// watchdog, mid-operation reset and back-to-back operations.
module tb_div_ctrl;

    localparam logic [3:0] OP_DIVW  = 4'b0001;
    localparam logic [3:0] OP_MODWU = 4'b1000;
    localparam logic [3:0] OP_DIVWU = 4'b0100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = '0;
    logic [31:0] req_src1 = '0;
    logic [31:0] req_src2 = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_result;
    logic        resp_ready = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        lat_err;
    logic        sdiv_tvalid;
    logic        sdiv_tready = 1'b0;
    logic [31:0] sdiv_dividend;
    logic [31:0] sdiv_divisor;
    logic        sdiv_dout_valid = 1'b0;
    logic [63:0] sdiv_dout = '0;
    logic        udiv_tvalid;
    logic        udiv_tready = 1'b0;
    logic [31:0] udiv_dividend;
    logic [31:0] udiv_divisor;
    logic        udiv_dout_valid = 1'b0;
    logic [63:0] udiv_dout = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_ctrl #(.MAX_LAT(48)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_result(resp_result), .resp_ready(resp_ready),
        .flush(flush), .busy(busy), .lat_err(lat_err),
        .sdiv_tvalid(sdiv_tvalid), .sdiv_tready(sdiv_tready),
        .sdiv_dividend(sdiv_dividend), .sdiv_divisor(sdiv_divisor),
        .sdiv_dout_valid(sdiv_dout_valid), .sdiv_dout(sdiv_dout),
        .udiv_tvalid(udiv_tvalid), .udiv_tready(udiv_tready),
        .udiv_dividend(udiv_dividend), .udiv_divisor(udiv_divisor),
        .udiv_dout_valid(udiv_dout_valid), .udiv_dout(udiv_dout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until the accepting edge has passed.
    task automatic accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        for (int i = 0; i < 20 && !req_ready; i++) step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: req_ready=%b expected 1", req_ready);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic issue(input logic sgn);
        if (sgn) sdiv_tready = 1'b1; else udiv_tready = 1'b1;
        step();
        sdiv_tready = 1'b0;
        udiv_tready = 1'b0;
    endtask

    task automatic deliver(input logic sgn, input logic [63:0] d);
        if (sgn) begin
            sdiv_dout_valid = 1'b1; sdiv_dout = d;
        end else begin
            udiv_dout_valid = 1'b1; udiv_dout = d;
        end
        step();
        sdiv_dout_valid = 1'b0;
        udiv_dout_valid = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({req_ready, resp_valid, busy, lat_err, sdiv_tvalid, udiv_tvalid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: {rdy,rv,busy,lat,sv,uv}=%b expected 000000",
                     {req_ready, resp_valid, busy, lat_err, sdiv_tvalid, udiv_tvalid});
        end
        checks++;
        if ({resp_result, sdiv_dividend, udiv_divisor} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: result=%h dividend=%h divisor=%h expected 0",
                     resp_result, sdiv_dividend, udiv_divisor);
        end
        resetn = 1'b1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: req_ready=%b expected 0", req_ready);
        end
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after: req_ready=%b expected 1", req_ready);
        end
    endtask

    task automatic test_div_signed();
        accept(OP_DIVW, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if ({sdiv_tvalid, udiv_tvalid, busy, req_ready} !== 4'b1010) begin
            errors++;
            $display("FAIL divw_issue: {sv,uv,busy,rdy}=%b expected 1010",
                     {sdiv_tvalid, udiv_tvalid, busy, req_ready});
        end
        checks++;
        if (sdiv_dividend !== 32'hFFFF_FFF9 || sdiv_divisor !== 32'd2) begin
            errors++;
            $display("FAIL divw_operands: %h/%h expected fffffff9/00000002", sdiv_dividend, sdiv_divisor);
        end
        deliver(1'b1, {32'd99, 32'd99});
        checks++;
        if (sdiv_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL divw_ignore_dv_issue: sdiv_tvalid=%b expected 1", sdiv_tvalid);
        end
        issue(1'b1);
        checks++;
        if (sdiv_tvalid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL divw_wait: sdiv_tvalid=%b busy=%b expected 0 1", sdiv_tvalid, busy);
        end
        deliver(1'b0, {32'h1234_5678, 32'h9ABC_DEF0});
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL divw_ignore_udiv: resp_valid=%b expected 0", resp_valid);
        end
        deliver(1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_result !== 32'hFFFF_FFFD) begin
                errors++;
                $display("FAIL divw_result[%0d]: valid=%b result=%h expected 1 fffffffd",
                         i, resp_valid, resp_result);
            end
            if (i < 2) step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checks++;
        if ({resp_valid, busy, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL divw_consumed: {rv,busy,rdy}=%b expected 001", {resp_valid, busy, req_ready});
        end
    endtask

    task automatic test_mod_unsigned_backpressure();
        accept(OP_MODWU, 32'hFFFF_FFFF, 32'h10);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (udiv_tvalid !== 1'b1 || sdiv_tvalid !== 1'b0 ||
                udiv_dividend !== 32'hFFFF_FFFF || udiv_divisor !== 32'h10) begin
                errors++;
                $display("FAIL modwu_stall[%0d]: uv=%b sv=%b op=%h/%h expected 1 0 ffffffff/00000010",
                         i, udiv_tvalid, sdiv_tvalid, udiv_dividend, udiv_divisor);
            end
            step();
        end
        issue(1'b0);
        deliver(1'b0, {32'h0FFF_FFFF, 32'h0000_000F});
        checks++;
        if (resp_valid !== 1'b1 || resp_result !== 32'h0000_000F) begin
            errors++;
            $display("FAIL modwu_result: valid=%b result=%h expected 1 0000000f", resp_valid, resp_result);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_flush();
        // Flush three cycles into WAIT.
        accept(OP_DIVW, 32'd20, 32'd3);
        issue(1'b1);
        for (int i = 0; i < 3; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL flush_wait_drain[%0d]: rv=%b busy=%b expected 0 1", i, resp_valid, busy);
            end
            step();
        end
        deliver(1'b1, {32'd6, 32'd2});
        checks++;
        if ({resp_valid, busy, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL flush_wait_end: {rv,busy,rdy}=%b expected 001", {resp_valid, busy, req_ready});
        end
        // Flush while the divider is still stalling the issue.
        accept(OP_DIVW, 32'd9, 32'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (sdiv_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL flush_issue_tvalid: sdiv_tvalid=%b expected 1", sdiv_tvalid);
        end
        issue(1'b1);
        deliver(1'b1, {32'd2, 32'd1});
        checks++;
        if ({resp_valid, busy, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL flush_issue_end: {rv,busy,rdy}=%b expected 001", {resp_valid, busy, req_ready});
        end
        // Flush while the response is waiting for EX.
        accept(OP_DIVW, 32'd8, 32'd2);
        issue(1'b1);
        deliver(1'b1, {32'd4, 32'd0});
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({resp_valid, busy, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL flush_done: {rv,busy,rdy}=%b expected 001", {resp_valid, busy, req_ready});
        end
    endtask

    task automatic test_back_to_back();
        resp_ready = 1'b1;
        accept(OP_DIVWU, 32'd100, 32'd7);
        issue(1'b0);
        deliver(1'b0, {32'd14, 32'd2});
        checks++;
        if (resp_valid !== 1'b1 || resp_result !== 32'd14) begin
            errors++;
            $display("FAIL b2b_first: valid=%b result=%h expected 1 0000000e", resp_valid, resp_result);
        end
        step();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: rv=%b rdy=%b expected 0 1", resp_valid, req_ready);
        end
        accept(OP_DIVWU, 32'hFFFF_FFFF, 32'd0);
        checks++;
        if (udiv_divisor !== 32'd0 || udiv_dividend !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL b2b_div0_ops: %h/%h expected ffffffff/00000000", udiv_dividend, udiv_divisor);
        end
        issue(1'b0);
        deliver(1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
        checks++;
        if (resp_valid !== 1'b1 || resp_result !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL b2b_second: valid=%b result=%h expected 1 ffffffff", resp_valid, resp_result);
        end
        step();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_single_pulse: resp_valid=%b expected 0", resp_valid);
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_lat_err();
        accept(OP_DIVWU, 32'd50, 32'd10);
        issue(1'b0);
        for (int i = 0; i < 47; i++) step();
        checks++;
        if (lat_err !== 1'b0) begin
            errors++;
            $display("FAIL lat_before: lat_err=%b expected 0", lat_err);
        end
        step();
        checks++;
        if (lat_err !== 1'b1) begin
            errors++;
            $display("FAIL lat_at_limit: lat_err=%b expected 1", lat_err);
        end
        for (int i = 0; i < 4; i++) step();
        deliver(1'b0, {32'd5, 32'd0});
        checks++;
        if (resp_valid !== 1'b1 || resp_result !== 32'd5) begin
            errors++;
            $display("FAIL lat_result: valid=%b result=%h expected 1 00000005", resp_valid, resp_result);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checks++;
        if (lat_err !== 1'b1) begin
            errors++;
            $display("FAIL lat_sticky: lat_err=%b expected 1", lat_err);
        end
    endtask

    task automatic test_reset_mid_op();
        accept(OP_DIVW, 32'd77, 32'd7);
        issue(1'b1);
        resetn = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, busy, lat_err, sdiv_tvalid, udiv_tvalid} !== 6'b0 ||
            resp_result !== 32'd0 || sdiv_dividend !== 32'd0 || sdiv_divisor !== 32'd0) begin
            errors++;
            $display("FAIL midreset_outputs: ctrl=%b result=%h ops=%h/%h expected all 0",
                     {req_ready, resp_valid, busy, lat_err, sdiv_tvalid, udiv_tvalid},
                     resp_result, sdiv_dividend, sdiv_divisor);
        end
        step();
        step();
        resetn = 1'b1;
        step();
        accept(OP_DIVW, 32'd100, 32'd10);
        issue(1'b1);
        deliver(1'b1, {32'd10, 32'd0});
        checks++;
        if (resp_valid !== 1'b1 || resp_result !== 32'd10) begin
            errors++;
            $display("FAIL midreset_newop: valid=%b result=%h expected 1 0000000a", resp_valid, resp_result);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_div_signed();
        test_mod_unsigned_backpressure();
        test_flush();
        test_back_to_back();
        test_lat_err();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
